// File: rtl/wired_mdu_issuer.sv
// wired_mdu_issuer: request FIFO, issue and writeback front end for the
// 3-stage pipelined multiplier. This block owns the multiplier's global
// advance enable and presents its results to the writeback arbiter.
module wired_mdu_issuer #(
    parameter int DEPTH = 4,
    parameter int RID_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [RID_W-1:0] disp_wid_i,
    input  logic [1:0]       disp_op_i,
    input  logic [31:0]      disp_r0_i,
    input  logic [31:0]      disp_r1_i,
    output logic             mul_valid_o,
    output logic [RID_W-1:0] mul_wid_o,
    output logic [1:0]       mul_op_o,
    output logic [31:0]      mul_r0_o,
    output logic [31:0]      mul_r1_o,
    output logic             mul_en_o,
    input  logic             mul_valid_i,
    input  logic [RID_W-1:0] mul_wid_i,
    input  logic [31:0]      mul_result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [RID_W-1:0] wb_wid_o,
    output logic [31:0]      wb_result_o,
    output logic             idle_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Worst case outstanding: FIFO + three multiplier stages + writeback reg.
    localparam int CW = $clog2(DEPTH + 5);

    typedef struct packed {
        logic [RID_W-1:0] wid;
        logic [1:0]       op;
        logic [31:0]      r0;
        logic [31:0]      r1;
    } req_t;

    req_t             mem_q [DEPTH];
    req_t             head;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    inflight_q, inflight_d;
    logic             resp_valid_q, resp_valid_d;
    logic [RID_W-1:0] wb_wid_q, wb_wid_d;
    logic [31:0]      wb_result_q, wb_result_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic wb_hs;
    logic mul_load;

    // FIFO status and handshake decode; the enable is the only path from
    // wb_ready_i back into the multiplier.
    always_comb begin
        fifo_empty   = (wr_ptr_q == rd_ptr_q);
        fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        disp_ready_o = !fifo_full;
        mul_valid_o  = !fifo_empty;
        mul_en_o     = !resp_valid_q || wb_ready_i;
        push         = disp_valid_i && disp_ready_o;
        pop          = mul_valid_o && mul_en_o;
        mul_load     = mul_en_o && mul_valid_i;
        wb_hs        = resp_valid_q && wb_ready_i;
    end

    // Head entry drives the multiplier inputs whether or not it is valid.
    always_comb begin
        head      = mem_q[rd_ptr_q[AW-1:0]];
        mul_wid_o = head.wid;
        mul_op_o  = head.op;
        mul_r0_o  = head.r0;
        mul_r1_o  = head.r1;
    end

    // FIFO storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{wid: disp_wid_i, op: disp_op_i,
                                         r0: disp_r0_i, r1: disp_r1_i};
        end
    end

    // Next-state for pointers, outstanding count and writeback register.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q;
        resp_valid_d = resp_valid_q;
        wb_wid_d     = wb_wid_q;
        wb_result_d  = wb_result_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, wb_hs})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
        if (mul_load) begin
            resp_valid_d = 1'b1;
            wb_wid_d     = mul_wid_i;
            wb_result_d  = mul_result_i;
        end else if (wb_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    // Control state; reset and flush both return the block to empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inflight_q   <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inflight_q   <= inflight_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Writeback payload; only meaningful while resp_valid_q is set.
    always_ff @(posedge clk) begin
        wb_wid_q    <= wb_wid_d;
        wb_result_q <= wb_result_d;
    end

    // Writeback and idle outputs.
    always_comb begin
        wb_valid_o  = resp_valid_q;
        wb_wid_o    = wb_wid_q;
        wb_result_o = wb_result_q;
        idle_o      = (inflight_q == '0);
    end

endmodule
